// File: rtl/nanov_spi_ram_if.sv
// rtl/nanov_spi_ram_if.sv - SPI bus between the nanoV CPU (master) and the SPI RAM responder (slave)
// Signals:
//   spi_select      chip select, active-low, driven by the CPU
//   spi_mosi        serial data from the CPU, MSB first
//   spi_clk_enable  high on each clk cycle that is an SPI clock edge
//   spi_miso        registered serial data back to the CPU
interface nanov_spi_ram_if;
    logic spi_select;
    logic spi_mosi;
    logic spi_clk_enable;
    logic spi_miso;

    modport master (
        output spi_select,
        output spi_mosi,
        output spi_clk_enable,
        input  spi_miso
    );

    modport slave (
        input  spi_select,
        input  spi_mosi,
        input  spi_clk_enable,
        output spi_miso
    );
endinterface

// File: rtl/nanov_spi_ram.sv
// rtl/nanov_spi_ram.sv - 23LC-style SPI RAM responder (READ 0x03 / WRITE 0x02, 24-bit address)
// Ports:
//   clk   system clock shared with the CPU; SPI edges are clk cycles with spi_clk_enable high
//   rstn  synchronous active-low reset
//   spi   slave side of nanov_spi_ram_if (select, mosi, clk_enable in; miso out)
// Parameters:
//   ADDR_BITS  implemented address width; memory holds 2^ADDR_BITS bytes, upper address bits ignored
module nanov_spi_ram #(
    parameter int ADDR_BITS = 10
) (
    input  logic            clk,
    input  logic            rstn,
    nanov_spi_ram_if.slave  spi
);
    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] ADDR_ONE = 1;

    typedef enum logic [2:0] {
        S_CMD,
        S_ADDR,
        S_READ,
        S_WRITE,
        S_IGNORE
    } state_t;

    state_t                 state;
    logic [4:0]             bit_cnt;
    logic [7:0]             shreg;
    logic [ADDR_BITS-1:0]   addr;
    logic                   read_flag;
    logic                   miso_q;

    logic [7:0]             mem [0:DEPTH-1];

    logic                   spi_edge;
    logic [7:0]             shift_in;
    logic [ADDR_BITS-1:0]   addr_shift;
    logic [ADDR_BITS-1:0]   addr_inc;
    logic [7:0]             rd_at_shift;
    logic [7:0]             rd_at_inc;
    logic                   mem_we;

    assign spi_edge    = rstn && !spi.spi_select && spi.spi_clk_enable;
    assign shift_in    = {shreg[6:0], spi.spi_mosi};
    // Shifting into an ADDR_BITS-wide register keeps only the low address bits.
    assign addr_shift  = {addr[ADDR_BITS-2:0], spi.spi_mosi};
    assign addr_inc    = addr + ADDR_ONE;
    assign rd_at_shift = mem[addr_shift];
    assign rd_at_inc   = mem[addr_inc];
    assign mem_we      = spi_edge && (state == S_WRITE) && (bit_cnt == 5'd7);
    assign spi.spi_miso = miso_q;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr] <= shift_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= S_CMD;
            bit_cnt   <= '0;
            addr      <= '0;
            shreg     <= '0;
            read_flag <= 1'b0;
            miso_q    <= 1'b0;
        end else if (spi.spi_select) begin
            state   <= S_CMD;
            bit_cnt <= '0;
            miso_q  <= 1'b0;
        end else if (spi.spi_clk_enable) begin
            case (state)
                S_CMD: begin
                    shreg  <= shift_in;
                    miso_q <= 1'b0;
                    if (bit_cnt == 5'd7) begin
                        bit_cnt <= '0;
                        if (shift_in == 8'h03) begin
                            state     <= S_ADDR;
                            read_flag <= 1'b1;
                        end else if (shift_in == 8'h02) begin
                            state     <= S_ADDR;
                            read_flag <= 1'b0;
                        end else begin
                            state <= S_IGNORE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 5'd1;
                    end
                end
                S_ADDR: begin
                    addr   <= addr_shift;
                    miso_q <= 1'b0;
                    if (bit_cnt == 5'd23) begin
                        bit_cnt <= '0;
                        if (read_flag) begin
                            // No dummy cycles: MSB goes out on the last address edge.
                            state  <= S_READ;
                            shreg  <= {rd_at_shift[6:0], 1'b0};
                            miso_q <= rd_at_shift[7];
                        end else begin
                            state <= S_WRITE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 5'd1;
                    end
                end
                S_READ: begin
                    // shreg holds the not-yet-presented bits, left aligned.
                    if (bit_cnt == 5'd7) begin
                        bit_cnt <= '0;
                        addr    <= addr_inc;
                        shreg   <= {rd_at_inc[6:0], 1'b0};
                        miso_q  <= rd_at_inc[7];
                    end else begin
                        bit_cnt <= bit_cnt + 5'd1;
                        shreg   <= {shreg[6:0], 1'b0};
                        miso_q  <= shreg[7];
                    end
                end
                S_WRITE: begin
                    shreg  <= shift_in;
                    miso_q <= 1'b0;
                    if (bit_cnt == 5'd7) begin
                        bit_cnt <= '0;
                        addr    <= addr_inc;
                    end else begin
                        bit_cnt <= bit_cnt + 5'd1;
                    end
                end
                S_IGNORE: begin
                    miso_q <= 1'b0;
                end
                default: begin
                    state   <= S_CMD;
                    bit_cnt <= '0;
                    miso_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_nanov_spi_ram.sv
// tb/tb_nanov_spi_ram.sv - self-checking bench for nanov_spi_ram against a byte-array memory model
module tb_nanov_spi_ram;
    localparam int AB    = 10;
    localparam int DEPTH = 1 << AB;

    logic clk = 1'b0;
    logic rstn;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [7:0] model [0:DEPTH-1];
    logic [7:0] data_q [$];

    nanov_spi_ram_if bus ();

    nanov_spi_ram #(.ADDR_BITS(AB)) dut (
        .clk  (clk),
        .rstn (rstn),
        .spi  (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One enabled SPI edge, optionally preceded by idle (enable low) cycles
    // during which miso must hold its value.
    task automatic spi_edge(input logic mosi_bit, input bit gaps);
        logic held;
        if (gaps) begin
            int n;
            n = $urandom_range(0, 3);
            held = bus.spi_miso;
            repeat (n) begin
                @(negedge clk);
                bus.spi_select     = 1'b0;
                bus.spi_clk_enable = 1'b0;
                bus.spi_mosi       = 1'($urandom);
                @(posedge clk);
                #1;
                check_eq("gap_hold", 32'(bus.spi_miso), 32'(held));
            end
        end
        @(negedge clk);
        bus.spi_select     = 1'b0;
        bus.spi_clk_enable = 1'b1;
        bus.spi_mosi       = mosi_bit;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] b, input int nbits, input bit gaps);
        for (int i = 7; i > 7 - nbits; i--) spi_edge(b[i], gaps);
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] a, input bit gaps);
        logic [31:0] w;
        w = {cmd, a};
        for (int i = 31; i >= 0; i--) spi_edge(w[i], gaps);
    endtask

    task automatic deselect();
        @(negedge clk);
        bus.spi_select     = 1'b1;
        bus.spi_clk_enable = 1'($urandom);
        bus.spi_mosi       = 1'($urandom);
        @(posedge clk);
        #1;
        check_eq("desel_miso", 32'(bus.spi_miso), 32'd0);
    endtask

    // Streams data_q to address a; the model records each completed byte.
    task automatic do_write(input logic [23:0] a, input bit gaps);
        send_hdr(8'h02, a, gaps);
        for (int k = 0; k < data_q.size(); k++) begin
            send_bits(data_q[k], 8, gaps);
            model[(int'(a[AB-1:0]) + k) % DEPTH] = data_q[k];
        end
        deselect();
    endtask

    // Reads n bytes from a, sampling miso before each edge as the CPU would.
    task automatic do_read(input string tag, input logic [23:0] a, input int n, input bit gaps);
        logic [7:0] got;
        send_hdr(8'h03, a, gaps);
        for (int k = 0; k < n; k++) begin
            for (int i = 7; i >= 0; i--) begin
                got[i] = bus.spi_miso;
                spi_edge(1'($urandom), gaps);
            end
            check_eq(tag, 32'(got), 32'(model[(int'(a[AB-1:0]) + k) % DEPTH]));
        end
        deselect();
    endtask

    initial begin
        logic [7:0]  got;
        logic        any_hi;
        logic [23:0] ra;
        logic [7:0]  cmd;

        rstn               = 1'b0;
        bus.spi_select     = 1'b0;
        bus.spi_clk_enable = 1'b1;
        bus.spi_mosi       = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_miso", 32'(bus.spi_miso), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        deselect();

        // Fill all of memory in one stream (starting mid-array so it wraps).
        data_q.delete();
        for (int k = 0; k < DEPTH; k++) data_q.push_back(8'($urandom));
        do_write(24'h000200, 1'b0);

        // Write then read.
        data_q.delete();
        data_q.push_back(8'hA5);
        data_q.push_back(8'h3C);
        do_write(24'h000010, 1'b0);
        do_read("wr_rd", 24'h000010, 2, 1'b0);

        // Wrap-around in both directions, plus aliasing of upper address bits.
        data_q.delete();
        data_q.push_back(8'h11);
        data_q.push_back(8'h22);
        do_write(24'h0003FF, 1'b0);
        do_read("wrap", 24'h0003FF, 2, 1'b0);
        do_read("alias", 24'h0403FF, 2, 1'b0);
        check_eq("wrap_model0", 32'(model[0]), 32'h22);

        // Enable gaps on a read of 0x96.
        data_q.delete();
        data_q.push_back(8'h96);
        do_write(24'h000155, 1'b0);
        do_read("gaps", 24'h000155, 1, 1'b1);

        // Partial byte then deselect: only the full byte lands.
        data_q.delete();
        data_q.push_back(8'hFF);
        send_hdr(8'h02, 24'h000020, 1'b0);
        send_bits(8'hFF, 8, 1'b0);
        model[16'h20] = 8'hFF;
        send_bits(8'h5A, 5, 1'b0);
        deselect();
        do_read("partial", 24'h000020, 2, 1'b0);

        // Unknown command 0x9F with 40 ones: miso stays 0, memory untouched.
        send_bits(8'h9F, 8, 1'b0);
        any_hi = 1'b0;
        for (int i = 0; i < 40; i++) begin
            spi_edge(1'b1, 1'b0);
            any_hi |= bus.spi_miso;
        end
        check_eq("unk_miso", 32'(any_hi), 32'd0);
        deselect();
        do_read("unk_after", 24'h0003FF, 2, 1'b0);
        do_read("unk_after_ff", 24'h7FFFFF, 1, 1'b0);

        // Reset while the third data bit is on miso; select stays low.
        send_hdr(8'h03, 24'h000010, 1'b0);
        got = '0;
        got[7] = bus.spi_miso;
        spi_edge(1'b0, 1'b0);
        got[6] = bus.spi_miso;
        spi_edge(1'b0, 1'b0);
        got[5] = bus.spi_miso;
        check_eq("rst_prefix", 32'(got[7:5]), 32'(model[16'h10][7:5]));
        @(negedge clk);
        rstn               = 1'b0;
        bus.spi_clk_enable = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_mid_miso", 32'(bus.spi_miso), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        bus.spi_clk_enable = 1'b0;
        do_read("rst_after", 24'h000011, 1, 1'b0);

        // Randomized transactions against the model.
        for (int t = 0; t < 40; t++) begin
            ra = 24'($urandom);
            case ($urandom_range(0, 3))
                0: do_read("rnd_read", ra, $urandom_range(1, 4), 1'($urandom));
                1: begin
                    data_q.delete();
                    repeat ($urandom_range(1, 4)) data_q.push_back(8'($urandom));
                    do_write(ra, 1'($urandom));
                end
                2: begin
                    send_hdr(8'h02, ra, 1'b0);
                    for (int k = 0; k < $urandom_range(1, 2); k++) begin
                        got = 8'($urandom);
                        send_bits(got, 8, 1'b0);
                        model[(int'(ra[AB-1:0]) + k) % DEPTH] = got;
                    end
                    send_bits(8'($urandom), $urandom_range(1, 7), 1'b0);
                    deselect();
                end
                default: begin
                    do cmd = 8'($urandom); while (cmd == 8'h02 || cmd == 8'h03);
                    send_hdr(cmd, ra, 1'b0);
                    check_eq("rnd_unk_miso", 32'(bus.spi_miso), 32'd0);
                    deselect();
                end
            endcase
        end
        do_read("final_sweep", 24'h000000, 64, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/nanov_spi_ram.md
# nanoV_spi_ram

Synthesizable SPI RAM responder that sits on the far end of the nanoV CPU's SPI bus and serves its instruction fetches and data loads/stores. It decodes the 23LC-style READ (0x03) and WRITE (0x02) commands with a 24-bit address, backed by an internal byte array. It replaces a behavioural memory model so the CPU plus memory can be simulated and synthesized as one single-clock system.

## Interface
Parameters:
- ADDR_BITS, 10, implemented address width; memory is 2^ADDR_BITS bytes; upper address bits are ignored.

Ports:
- clk  input  1  system clock, same clock as the CPU; the SPI clock is clk gated by spi_clk_enable.
- rstn  input  1  reset, synchronous, active-low.
- spi_select  input  1  chip select, active-low, from the CPU.
- spi_mosi  input  1  serial data from the CPU (CPU's spi_out), MSB first.
- spi_clk_enable  input  1  high on each clk cycle that is an SPI clock edge.
- spi_miso  output  1  registered serial data to the CPU (CPU's spi_data_in).

## Operation
- An SPI edge is a posedge clk with rstn=1, spi_select=0 and spi_clk_enable=1. All state changes below happen only on SPI edges, except deselect and reset.
- States: CMD, ADDR, READ, WRITE, IGNORE. A 5-bit bit counter and an 8-bit shift register are shared across states.
- CMD: shift 8 bits MSB first. On the 8th bit:
  - 0x03 -> ADDR, read flag set.
  - 0x02 -> ADDR, read flag clear.
  - Any other value -> IGNORE.
- ADDR: shift 24 bits into the address register, MSB first; keep only the low ADDR_BITS bits. On the 24th bit, go to READ or WRITE.
  - If reading, on that same edge load the data shift register with mem[addr] and drive spi_miso <= mem[addr][7].
- READ: each SPI edge shifts out the next bit, MSB first.
  - After bit 0 of a byte has been presented for one edge, addr <= addr+1 (mod 2^ADDR_BITS).
  - On that same edge, the new byte's bit 7 appears on spi_miso.
  - Streaming continues until deselect.
- WRITE: shift 8 bits in. On the 8th bit, write mem[addr] <= byte and addr <= addr+1 (mod 2^ADDR_BITS). Streaming continues until deselect.
  - A partial byte at deselect is discarded; no write occurs.
- IGNORE: spi_mosi is ignored and spi_miso is held at 0 until deselect.
- Deselect: spi_select=1 at any posedge clk returns the block to CMD, clears the bit counter and drives spi_miso <= 0. This holds in every state, mid-byte included.
- spi_miso is 0 in CMD, ADDR (except the final ADDR edge), WRITE and IGNORE.
- spi_clk_enable=0 with select low: hold all state and spi_miso.

## Timing
- Reset (rstn=0 at posedge clk): state=CMD, bit counter=0, address=0, spi_miso=0.
  - Memory contents are not reset.
  - Reset overrides select and enable.
  - Reset mid-write aborts any partial byte; completed bytes remain written.
- Read latency: the data MSB is valid on spi_miso in the cycle immediately after the 32nd SPI edge (last address bit). The CPU samples it on the next SPI edge, so there are no dummy cycles.
- A write byte is committed on the edge that samples its 8th bit. A READ issued on the following transaction returns it.
- Deselect and reselect on consecutive cycles is legal. The first SPI edge after reselect is command bit 7.
- Address wrap: 2^ADDR_BITS-1 increments to 0 for both read and write streams.

## Test plan
- Write then read:
  - Stimulus: WRITE 0x02, addr 0x000010, data 0xA5 0x3C; deselect; READ 0x03, addr 0x000010.
  - Required: spi_miso streams 1010_0101 then 0011_1100, first bit valid the cycle after the 32nd edge.
- Wrap-around:
  - Stimulus: with ADDR_BITS=10, write 0x11 to 0x3FF and 0x22 to 0x000 in one stream; read from 0x3FF for 2 bytes.
  - Required: 0x11 then 0x22. Address 0x0403FF aliases to 0x3FF.
- Enable gaps:
  - Stimulus: READ of a preloaded byte 0x96 with spi_clk_enable toggling randomly.
  - Required: the sampled bits are still 1001_0110, and spi_miso only changes on enabled edges.
- Partial byte and deselect:
  - Stimulus: WRITE to 0x20 with 0xFF, then 5 bits of a second byte, then deselect.
  - Required: mem[0x20]=0xFF and mem[0x21] unchanged. The next transaction decodes a fresh command.
- Unknown command:
  - Stimulus: command 0x9F followed by 40 bits of 1s.
  - Required: no memory change, spi_miso=0 throughout, and a following READ works normally.
- Reset mid-read:
  - Stimulus: rstn=0 for 1 cycle during the 3rd data bit.
  - Required: spi_miso=0 the next cycle, and the block decodes a new command after reset with select still low.
